// File: rtl/network_pkg.sv
// Shared types and helpers for the spike-count decoder.
//   decoder_state_t : decoder FSM state encoding
//   spike_cnt_t     : spike counter at the default width (the decoder's CNT_W parameter
//                     sets the width actually used)
//   id_width()      : class index width, kept at least 1 bit so a one-neuron layer still builds
package network_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StArgmax,
        StResult
    } decoder_state_t;

    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef logic [DEFAULT_CNT_W-1:0] spike_cnt_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// Saturating per-neuron spike counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   clear : synchronous clear at the start of a window
//   inc   : add one this cycle (ignored once the count is all ones)
//   count : current count
module spike_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spike_count_decoder.sv
// Rate-coded classifier: counts spikes per output neuron over WINDOW_LEN valid timesteps,
// then scans the counters one per cycle to find the most active neuron.
//   clk, rst       : clock and synchronous active-high reset
//   start          : opens a window (only honoured while idle)
//   spike_valid    : output_spikes carries one timestep this cycle
//   output_spikes  : spike vector from the neuron layer
//   busy           : accumulating or scanning
//   class_valid    : result held, waiting for class_ready
//   class_ready    : consumer accepts the result
//   class_id       : winning neuron (lowest index on a tie)
//   class_count    : winning neuron's spike count
//   tie            : another neuron matched the winning count
//   no_spike       : every count was zero
module spike_count_decoder
    import network_pkg::*;
#(
    parameter  int unsigned NEURON_COUNT = 10,
    parameter  int unsigned WINDOW_LEN   = 500,
    parameter  int unsigned CNT_W        = 16,
    localparam int unsigned ID_W         = id_width(NEURON_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             spike_valid,
    input  logic             output_spikes [NEURON_COUNT-1:0],
    output logic             busy,
    output logic             class_valid,
    input  logic             class_ready,
    output logic [ID_W-1:0]  class_id,
    output logic [CNT_W-1:0] class_count,
    output logic             tie,
    output logic             no_spike
);

    localparam int unsigned     STEP_W    = $clog2(WINDOW_LEN + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_LEN - 1);
    localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(NEURON_COUNT - 1);

    decoder_state_t   state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [ID_W-1:0]  idx_q, idx_d;
    logic [ID_W-1:0]  best_q, best_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             tie_run_q, tie_run_d;
    logic [ID_W-1:0]  class_id_q, class_id_d;
    logic [CNT_W-1:0] class_count_q, class_count_d;
    logic             tie_q, tie_d;
    logic             no_spike_q, no_spike_d;

    logic             clear_cnt;
    logic             acc_en;
    logic [CNT_W-1:0] counts [NEURON_COUNT];
    logic [CNT_W-1:0] cur;

    for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_cnt
        spike_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clear(clear_cnt),
            .inc  (acc_en & output_spikes[g]),
            .count(counts[g])
        );
    end

    // Single comparator: the scan index selects which counter is compared this cycle.
    assign cur = counts[idx_q];

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        idx_d         = idx_q;
        best_d        = best_q;
        max_d         = max_q;
        tie_run_d     = tie_run_q;
        class_id_d    = class_id_q;
        class_count_d = class_count_q;
        tie_d         = tie_q;
        no_spike_d    = no_spike_q;
        clear_cnt     = 1'b0;
        acc_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear_cnt = 1'b1;
                    step_d    = '0;
                    idx_d     = '0;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                if (spike_valid) begin
                    acc_en = 1'b1;
                    step_d = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        idx_d   = '0;
                        state_d = StArgmax;
                    end
                end
            end
            StArgmax: begin
                // Index 0 seeds the running maximum; later indices replace it only when
                // strictly greater, so ties resolve to the lowest index.
                if ((idx_q == '0) || (cur > max_q)) begin
                    max_d     = cur;
                    best_d    = idx_q;
                    tie_run_d = 1'b0;
                end else if (cur == max_q) begin
                    tie_run_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    class_id_d    = best_d;
                    class_count_d = max_d;
                    tie_d         = tie_run_d;
                    no_spike_d    = (max_d == '0);
                    state_d       = StResult;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StResult: begin
                if (class_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            step_q        <= '0;
            idx_q         <= '0;
            best_q        <= '0;
            max_q         <= '0;
            tie_run_q     <= 1'b0;
            class_id_q    <= '0;
            class_count_q <= '0;
            tie_q         <= 1'b0;
            no_spike_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            best_q        <= best_d;
            max_q         <= max_d;
            tie_run_q     <= tie_run_d;
            class_id_q    <= class_id_d;
            class_count_q <= class_count_d;
            tie_q         <= tie_d;
            no_spike_q    <= no_spike_d;
        end
    end

    assign busy        = (state_q == StAccum) || (state_q == StArgmax);
    assign class_valid = (state_q == StResult);
    assign class_id    = class_id_q;
    assign class_count = class_count_q;
    assign tie         = tie_q;
    assign no_spike    = no_spike_q;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Bench for spike_count_decoder: two instances (wide counters, and 2-bit counters to reach
// saturation), directed windows plus randomized windows checked against a counting model.
module tb_spike_count_decoder;

    localparam int unsigned NA = 10;
    localparam int unsigned WA = 4;
    localparam int unsigned CA = 16;
    localparam int unsigned IA = $clog2(NA);
    localparam int unsigned NB = 4;
    localparam int unsigned WB = 8;
    localparam int unsigned CB = 2;
    localparam int unsigned IB = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst;

    logic          start_a, valid_a, ready_a;
    logic          spikes_a [NA-1:0];
    logic          busy_a, cv_a, tie_a, nos_a;
    logic [IA-1:0] id_a;
    logic [CA-1:0] cnt_a;

    logic          start_b, valid_b, ready_b;
    logic          spikes_b [NB-1:0];
    logic          busy_b, cv_b, tie_b, nos_b;
    logic [IB-1:0] id_b;
    logic [CB-1:0] cnt_b;

    int            n_vec = 0;
    int            n_err = 0;
    logic [15:0]   beat_q [$];

    always #5 clk = ~clk;

    spike_count_decoder #(
        .NEURON_COUNT(NA),
        .WINDOW_LEN  (WA),
        .CNT_W       (CA)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start_a),
        .spike_valid  (valid_a),
        .output_spikes(spikes_a),
        .busy         (busy_a),
        .class_valid  (cv_a),
        .class_ready  (ready_a),
        .class_id     (id_a),
        .class_count  (cnt_a),
        .tie          (tie_a),
        .no_spike     (nos_a)
    );

    spike_count_decoder #(
        .NEURON_COUNT(NB),
        .WINDOW_LEN  (WB),
        .CNT_W       (CB)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start_b),
        .spike_valid  (valid_b),
        .output_spikes(spikes_b),
        .busy         (busy_b),
        .class_valid  (cv_b),
        .class_ready  (ready_b),
        .class_id     (id_b),
        .class_count  (cnt_b),
        .tie          (tie_b),
        .no_spike     (nos_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic v, input logic [15:0] bits);
        if (sel) begin
            start_b = st;
            valid_b = v;
            for (int i = 0; i < NB; i++) spikes_b[i] = bits[i];
        end else begin
            start_a = st;
            valid_a = v;
            for (int i = 0; i < NA; i++) spikes_a[i] = bits[i];
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) ready_b = r;
        else     ready_a = r;
    endtask

    function automatic logic get_cv(input bit sel);
        return sel ? cv_b : cv_a;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic read_out(input bit sel, output logic [31:0] id, output logic [31:0] cnt,
                            output logic t, output logic ns);
        if (sel) begin
            id = 32'(id_b); cnt = 32'(cnt_b); t = tie_b; ns = nos_b;
        end else begin
            id = 32'(id_a); cnt = 32'(cnt_a); t = tie_a; ns = nos_a;
        end
    endtask

    // Spike totals per neuron over the window, clipped to the counter range; winner is the
    // lowest index holding the maximum, tie means the maximum occurs more than once.
    task automatic model(input int n, input int cw, output int id, output int cnt,
                         output logic t, output logic ns);
        int counts [16];
        int sat;
        int maxv;
        int nmax;
        sat = (1 << cw) - 1;
        for (int i = 0; i < 16; i++) counts[i] = 0;
        foreach (beat_q[b]) for (int i = 0; i < n; i++) counts[i] += int'(beat_q[b][i]);
        maxv = 0;
        for (int i = 0; i < n; i++) begin
            if (counts[i] > sat) counts[i] = sat;
            if (counts[i] > maxv) maxv = counts[i];
        end
        id   = -1;
        nmax = 0;
        for (int i = 0; i < n; i++) begin
            if (counts[i] == maxv) begin
                nmax++;
                if (id < 0) id = i;
            end
        end
        cnt = maxv;
        t   = (nmax > 1);
        ns  = (maxv == 0);
    endtask

    // One full window from beat_q. gaps inserts idle (spike_valid=0) cycles with junk spikes
    // and stray start pulses; latency is counted with the first-beat cycle as cycle 1.
    task automatic run_window(input bit sel, input bit gaps, input int ready_wait,
                              input bit chk_lat, input bit abort, input string tag);
        int          n, w, cw, lat, cyc;
        int          e_id, e_cnt;
        logic        e_tie, e_ns;
        logic [31:0] o_id, o_cnt;
        logic        o_tie, o_ns;
        n  = sel ? NB : NA;
        w  = sel ? WB : WA;
        cw = sel ? CB : CA;
        model(n, cw, e_id, e_cnt, e_tie, e_ns);

        drive(sel, 1'b1, 1'b0, 16'h0);
        tick();
        chk({tag, "_busy_after_start"}, 32'(get_busy(sel)), 32'd1);
        lat = 0;
        foreach (beat_q[b]) begin
            if (gaps) begin
                int k;
                k = $urandom_range(0, 2);
                for (int g = 0; g < k; g++) begin
                    drive(sel, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
                    tick();
                    if (lat > 0) lat++;
                end
            end
            drive(sel, 1'($urandom_range(0, 1)), 1'b1, beat_q[b]);
            if (lat == 0) lat = 1;
            tick();
            lat++;
        end

        cyc = 0;
        while (get_cv(sel) !== 1'b1 && cyc < 200) begin
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            tick();
            cyc++;
            lat++;
        end
        drive(sel, 1'b0, 1'b0, 16'h0);
        chk({tag, "_class_valid"}, 32'(get_cv(sel)), 32'd1);
        chk({tag, "_argmax_cycles"}, cyc, n);
        if (chk_lat) chk({tag, "_latency"}, lat, w + n + 1);
        chk({tag, "_busy_in_result"}, 32'(get_busy(sel)), 32'd0);
        read_out(sel, o_id, o_cnt, o_tie, o_ns);
        chk({tag, "_class_id"}, o_id, e_id);
        chk({tag, "_class_count"}, o_cnt, e_cnt);
        chk({tag, "_tie"}, 32'(o_tie), 32'(e_tie));
        chk({tag, "_no_spike"}, 32'(o_ns), 32'(e_ns));

        if (abort) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            read_out(sel, o_id, o_cnt, o_tie, o_ns);
            chk({tag, "_rst_valid"}, 32'(get_cv(sel)), 32'd0);
            chk({tag, "_rst_id"}, o_id, 32'd0);
            chk({tag, "_rst_count"}, o_cnt, 32'd0);
            chk({tag, "_rst_tie_ns"}, {30'd0, o_tie, o_ns}, 32'd0);
            return;
        end

        set_ready(sel, 1'b0);
        for (int c = 0; c < ready_wait; c++) begin
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            tick();
            read_out(sel, o_id, o_cnt, o_tie, o_ns);
            chk({tag, "_hold_valid"}, 32'(get_cv(sel)), 32'd1);
            chk({tag, "_hold_out"}, {o_id[15:0], o_cnt[13:0], o_tie, o_ns},
                {16'(e_id), 14'(e_cnt), e_tie, e_ns});
        end
        drive(sel, 1'($urandom_range(0, 1)), 1'b0, 16'h0);
        set_ready(sel, 1'b1);
        tick();
        set_ready(sel, 1'b0);
        drive(sel, 1'b0, 1'b0, 16'h0);
        read_out(sel, o_id, o_cnt, o_tie, o_ns);
        chk({tag, "_idle_valid"}, 32'(get_cv(sel)), 32'd0);
        chk({tag, "_idle_busy"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_idle_keep"}, {o_id[15:0], o_cnt[13:0], o_tie, o_ns},
            {16'(e_id), 14'(e_cnt), e_tie, e_ns});
    endtask

    initial begin
        logic seen;
        rst     = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) tick();
        rst = 1'b0;

        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_valid", 32'(cv_a), 32'd0);
        chk("reset_id", 32'(id_a), 32'd0);
        chk("reset_count", 32'(cnt_a), 32'd0);
        chk("reset_tie_ns", {30'd0, tie_a, nos_a}, 32'd0);
        chk("reset_b", {busy_b, cv_b, tie_b, nos_b, 2'(id_b), 2'(cnt_b)}, 8'd0);

        // Neuron 3 fires every beat, back to back.
        beat_q = '{16'h0008, 16'h0008, 16'h0008, 16'h0008};
        run_window(1'b0, 1'b0, 0, 1'b1, 1'b0, "single");

        // Neurons 2 and 7 three spikes each: lower index wins, tie flagged.
        beat_q = '{16'h0084, 16'h0084, 16'h0000, 16'h0084};
        run_window(1'b0, 1'b1, 1, 1'b1 ^ 1'b1, 1'b0, "tie");

        // Silent window.
        beat_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_window(1'b0, 1'b0, 0, 1'b1, 1'b0, "silent");

        // Consumer stalls 20 cycles with start pulses; the next window starts right away.
        beat_q = '{16'h0201, 16'h0200, 16'h0010, 16'h0200};
        run_window(1'b0, 1'b0, 20, 1'b1, 1'b0, "stall");
        beat_q = '{16'h0010, 16'h0030, 16'h0000, 16'h0020};
        run_window(1'b0, 1'b0, 2, 1'b1, 1'b0, "back2back");

        // 2-bit counters: 6 spikes clip to 3; two clipped neurons tie.
        beat_q = '{16'h2, 16'h2, 16'h8, 16'h2, 16'h2, 16'h8, 16'h2, 16'h2};
        run_window(1'b1, 1'b0, 0, 1'b1, 1'b0, "saturate");
        beat_q = '{16'h5, 16'h4, 16'h5, 16'h4, 16'h5, 16'h4, 16'h4, 16'h4};
        run_window(1'b1, 1'b1, 1, 1'b0, 1'b0, "sat_tie");

        // Reset after two beats (together with start): window abandoned, counters cleared.
        beat_q = '{16'h0020, 16'h0020};
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        foreach (beat_q[b]) begin
            drive(1'b0, 1'b0, 1'b1, beat_q[b]);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 16'h0020);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_outputs", {cv_a, tie_a, nos_a, 4'(id_a), 16'(cnt_a)}, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (cv_a) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        beat_q = '{16'h0022, 16'h0002, 16'h0000, 16'h0000};
        run_window(1'b0, 1'b0, 0, 1'b1, 1'b0, "restart");

        // Reset while the result is held.
        beat_q = '{16'h0100, 16'h0100, 16'h0001, 16'h0100};
        run_window(1'b0, 1'b0, 0, 1'b1, 1'b1, "rst_result");

        for (int r = 0; r < 12; r++) begin
            beat_q.delete();
            for (int b = 0; b < WA; b++) beat_q.push_back(16'($urandom) & 16'($urandom));
            run_window(1'b0, 1'b1, $urandom_range(0, 4), 1'b0, 1'b0, "rand_a");
        end
        for (int r = 0; r < 6; r++) begin
            beat_q.delete();
            for (int b = 0; b < WB; b++) beat_q.push_back(16'($urandom) & 16'($urandom));
            run_window(1'b1, 1'b1, $urandom_range(0, 4), 1'b0, 1'b0, "rand_b");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spike_count_decoder.md
SPIKE_COUNT_DECODER -- requirements
Module: spike_count_decoder

Interface
REQ-001 SHALL have parameter NEURON_COUNT, default 10, number of output neurons decoded.
REQ-002 SHALL have parameter WINDOW_LEN, default 500, number of valid timesteps per classification window.
REQ-003 SHALL have parameter CNT_W, default 16, per-neuron spike-counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: start  input  1  one-cycle pulse that opens a window; honoured only in IDLE.
REQ-007 SHALL have port: spike_valid  input  1  output_spikes holds one timestep this cycle.
REQ-008 SHALL have port: output_spikes  input  unpacked logic [NEURON_COUNT-1:0]  spike vector from the neuron layer.
REQ-009 SHALL have port: busy  output  1  high in ACCUM or ARGMAX.
REQ-010 SHALL have port: class_valid  output  1  result available; high only in RESULT.
REQ-011 SHALL have port: class_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port: class_id  output  $clog2(NEURON_COUNT)  index of the winning neuron.
REQ-013 SHALL have port: class_count  output  CNT_W  spike count of the winning neuron.
REQ-014 SHALL have port: tie  output  1  another neuron equalled the winning count.
REQ-015 SHALL have port: no_spike  output  1  every count was zero.

Function
REQ-016 SHALL implement states IDLE, ACCUM, ARGMAX and RESULT.
REQ-017 SHALL, in IDLE with start=1, clear all counters and the step counter and enter ACCUM on the next cycle.
REQ-018 SHALL, in ACCUM, add output_spikes[i] to counter i and increment the step counter on each spike_valid=1 cycle; spike_valid=0 cycles change nothing.
REQ-019 SHALL saturate each counter at 2^CNT_W-1 with no wrap-around.
REQ-020 SHALL enter ARGMAX on the cycle after the spike_valid beat that brings the step count to WINDOW_LEN; that final beat is counted.
REQ-021 SHALL, in ARGMAX, compare one neuron per cycle, indices 0 to NEURON_COUNT-1, using a strictly-greater comparison so a tie keeps the lowest index; ARGMAX lasts exactly NEURON_COUNT cycles.
REQ-022 SHALL set tie when any later index equals the running maximum, and clear tie when a strictly greater count replaces the maximum.
REQ-023 SHALL set no_spike when the final maximum is 0; class_id is then 0.
REQ-024 SHALL enter RESULT after ARGMAX and hold class_valid=1 with class_id, class_count, tie and no_spike stable until class_ready=1.
REQ-025 SHALL return to IDLE on the cycle after class_valid=1 and class_ready=1; a new start SHALL be accepted on that IDLE cycle at the earliest.
REQ-026 SHALL ignore start while in ACCUM, ARGMAX or RESULT, and ignore spike_valid outside ACCUM.
REQ-027 SHALL give a latency of WINDOW_LEN valid beats + NEURON_COUNT + 1 cycles from the first valid beat to class_valid.
REQ-028 SHALL keep class_id, class_count, tie and no_spike at their last values while in IDLE.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, force IDLE, clear all counters and the step counter, and drive busy=0, class_valid=0, class_id=0, class_count=0, tie=0 and no_spike=0.
REQ-030 SHALL, when rst is asserted mid-window or mid-result, abandon the window without emitting a result.
REQ-031 SHALL take precedence over start.

Structure
REQ-032 SHALL place decoder_state_t and spike_cnt_t (logic [CNT_W-1:0]) in network_pkg.
REQ-033 SHALL instantiate NEURON_COUNT copies of sub-module spike_counter, which provides a clear input, a conditional increment and saturation.
REQ-034 SHALL implement the argmax as a single sequential comparator rather than a combinational tree.

Verification
REQ-035 SHALL cover: WINDOW_LEN=4, neuron 3 spiking on all 4 beats and the others silent -> class_id=3, class_count=4, tie=0, class_valid exactly 4+NEURON_COUNT+1 cycles after the first beat.
REQ-036 SHALL cover: neurons 2 and 7 each with 3 spikes -> class_id=2, tie=1.
REQ-037 SHALL cover: all-zero spikes for the whole window -> no_spike=1, class_id=0, class_count=0.
REQ-038 SHALL cover: CNT_W=2 with one neuron spiking 6 times -> class_count=3 (saturated).
REQ-039 SHALL cover: class_ready held low for 20 cycles, with start pulsed while waiting -> outputs stable, start ignored, IDLE one cycle after ready.
REQ-040 SHALL cover: rst after 2 of 4 beats, then a new start -> no class_valid from the aborted window, and the new window counts from zero.
